// File: rtl/pattern_stream_pkg.sv
// pattern_stream_pkg: shared FSM state type and saturating add for the pattern stream accumulator
package pattern_stream_pkg;
  typedef enum logic [1:0] {PS_IDLE, PS_ACCUM, PS_REPORT} ps_state_t;
  // Returns {overflow, clamped sum}; all operands zero-extended to 32 bits, so max must fit in 32 bits.
  function automatic logic [32:0] sat_add(input logic [31:0] acc, input logic [31:0] inc, input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, acc} + {1'b0, inc};
    return (sum > {1'b0, max}) ? {1'b1, max} : sum;
  endfunction
endpackage

// File: rtl/pattern_stream_accumulator_window.sv
// window_match_count: counts pattern matches in the top NUM_WIN windows of a vector
//   vec_i   : vector, MSB is earliest bit; window i is vec_i[VEC_WIDTH-1-i -: PATTERN_WIDTH]
//   pat_i   : pattern compared against each window
//   en_i    : per-window enable, bit i gates window i
//   count_o : number of enabled matching windows
module window_match_count #(
  parameter int VEC_WIDTH     = 10,
  parameter int PATTERN_WIDTH = 3,
  parameter int NUM_WIN       = 8,
  localparam int CW           = $clog2(NUM_WIN + 1)
) (
  input  logic [VEC_WIDTH-1:0]     vec_i,
  input  logic [PATTERN_WIDTH-1:0] pat_i,
  input  logic [NUM_WIN-1:0]       en_i,
  output logic [CW-1:0]            count_o
);
  always_comb begin
    count_o = '0;
    for (int i = 0; i < NUM_WIN; i++)
      count_o = count_o + CW'(en_i[i] && (vec_i[VEC_WIDTH-1-i -: PATTERN_WIDTH] == pat_i));
  end
endmodule

// File: rtl/pattern_stream_accumulator.sv
// pattern_stream_accumulator: counts pattern occurrences across a framed word stream, one total per frame
//   Clk/Rst                   : clock, synchronous active-high reset
//   InValid/InReady/InData/InLast : input word stream, beat = InValid & InReady, MSB earliest
//   Pattern                   : pattern, taken from the first beat of each frame
//   OutValid/OutReady/OutCount/OutSat : frame total with saturation flag, held until accepted
module pattern_stream_accumulator
  import pattern_stream_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int PATTERN_WIDTH = 3,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [DATA_WIDTH-1:0]    InData,
  input  logic                     InLast,
  input  logic [PATTERN_WIDTH-1:0] Pattern,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [COUNT_WIDTH-1:0]   OutCount,
  output logic                     OutSat
);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [31:0] MAX = 32'((64'd1 << COUNT_WIDTH) - 64'd1);
  // The first beat has no predecessor, so windows reaching into the carry bits are disabled.
  localparam logic [DATA_WIDTH-1:0] FIRST_EN = {DATA_WIDTH{1'b1}} << (PATTERN_WIDTH - 1);
  if (PATTERN_WIDTH < 2 || PATTERN_WIDTH > DATA_WIDTH) begin : g_bad_pattern
    $error("PATTERN_WIDTH must be in 2..DATA_WIDTH");
  end
  ps_state_t                state_q, state_d;
  logic [PATTERN_WIDTH-1:0] pat_q, pat_d, pat_eff;
  logic [PATTERN_WIDTH-2:0] carry_q, carry_d;
  logic [COUNT_WIDTH-1:0]   acc_q, acc_d, cnt_q, cnt_d, sum;
  logic                     sat_q, sat_d, osat_q, osat_d, first, beat, ovf;
  logic [BW-1:0]            beat_cnt;
  logic [32:0]              sum_full;
  assign first    = state_q == PS_IDLE;
  assign InReady  = state_q != PS_REPORT;
  assign OutValid = state_q == PS_REPORT;
  assign OutCount = cnt_q;
  assign OutSat   = osat_q;
  assign beat     = InValid && InReady;
  assign pat_eff  = first ? Pattern : pat_q;
  window_match_count #(
    .VEC_WIDTH    (DATA_WIDTH + PATTERN_WIDTH - 1),
    .PATTERN_WIDTH(PATTERN_WIDTH),
    .NUM_WIN      (DATA_WIDTH)
  ) u_win (
    .vec_i  ({carry_q, InData}),
    .pat_i  (pat_eff),
    .en_i   (first ? FIRST_EN : {DATA_WIDTH{1'b1}}),
    .count_o(beat_cnt)
  );
  assign sum_full = sat_add(32'(acc_q), 32'(beat_cnt), MAX);
  assign sum      = sum_full[COUNT_WIDTH-1:0];
  // Clamped value never exceeds MAX, so the bits above COUNT_WIDTH are zero unless overflow set bit 32.
  assign ovf      = |sum_full[32:COUNT_WIDTH];
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    osat_d  = osat_q;
    if (beat) begin
      carry_d = InData[PATTERN_WIDTH-2:0];
      acc_d   = sum;
      sat_d   = (!first && sat_q) || ovf;
      pat_d   = pat_eff;
      state_d = InLast ? PS_REPORT : PS_ACCUM;
      if (InLast) begin
        cnt_d  = sum;
        osat_d = (!first && sat_q) || ovf;
      end
    end
    if (OutValid && OutReady) begin
      state_d = PS_IDLE;
      carry_d = '0;
      acc_d   = '0;
      sat_d   = 1'b0;
    end
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= PS_IDLE;
      pat_q   <= '0;
      carry_q <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
      osat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
      osat_q  <= osat_d;
    end
  end
endmodule

// File: tb/tb_pattern_stream_accumulator.sv
// tb_pattern_stream_accumulator: scoreboard bench driving a 16-bit and a 4-bit count instance in lockstep
module tb_pattern_stream_accumulator;
  logic        clk = 1'b0, rst, in_valid, in_last, out_ready;
  logic [7:0]  in_data;
  logic [2:0]  pattern;
  logic        in_ready, out_valid, out_sat, in_ready4, out_valid4, out_sat4;
  logic [15:0] out_count;
  logic [3:0]  out_count4;
  logic [16:0] q16[$];
  logic [4:0]  q4[$];
  logic [16:0] e16;
  logic [4:0]  e4;
  int          n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  pattern_stream_accumulator #(.DATA_WIDTH(8), .PATTERN_WIDTH(3), .COUNT_WIDTH(16)) dut (
    .Clk(clk), .Rst(rst), .InValid(in_valid), .InReady(in_ready), .InData(in_data), .InLast(in_last),
    .Pattern(pattern), .OutValid(out_valid), .OutReady(out_ready), .OutCount(out_count), .OutSat(out_sat)
  );
  pattern_stream_accumulator #(.DATA_WIDTH(8), .PATTERN_WIDTH(3), .COUNT_WIDTH(4)) dut4 (
    .Clk(clk), .Rst(rst), .InValid(in_valid), .InReady(in_ready4), .InData(in_data), .InLast(in_last),
    .Pattern(pattern), .OutValid(out_valid4), .OutReady(out_ready), .OutCount(out_count4), .OutSat(out_sat4)
  );
  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q16.size() == 0) check("unexpected result16", 1, 0);
      else begin
        e16 = q16.pop_front();
        check("count16", 32'(out_count), 32'(e16[15:0]));
        check("sat16", 32'(out_sat), 32'(e16[16]));
      end
    end
    if (!rst && out_valid4 && out_ready) begin
      if (q4.size() == 0) check("unexpected result4", 1, 0);
      else begin
        e4 = q4.pop_front();
        check("count4", 32'(out_count4), 32'(e4[3:0]));
        check("sat4", 32'(out_sat4), 32'(e4[4]));
      end
    end
  end
  task automatic expect_frame(input logic [15:0] c16, input logic s16, input logic [3:0] c4, input logic s4);
    q16.push_back({s16, c16});
    q4.push_back({s4, c4});
  endtask
  task automatic send(input logic [7:0] d, input logic last, input logic [2:0] p);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    pattern  = p;
    for (int n = 0; !in_ready && n < 50; n++) begin
      @(posedge clk);
      #1;
    end
    if (!in_ready) check("inready timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; pattern = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset outvalid", 32'(out_valid), 0);
    check("reset inready", 32'(in_ready), 1);
    check("reset outcount", 32'(out_count), 0);
    check("reset outsat", 32'(out_sat), 0);
    // single beat, then held under backpressure
    out_ready = 1'b0;
    expect_frame(16'd3, 1'b0, 4'd3, 1'b0);
    send(8'b10101010, 1'b1, 3'b101);
    check("t1 outvalid latency", 32'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1; pattern = 3'b111;
      @(posedge clk);
      #1;
      check("bp inready", 32'(in_ready), 0);
      check("bp outvalid", 32'(out_valid), 1);
      check("bp outcount", 32'(out_count), 3);
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release outvalid", 32'(out_valid), 0);
    check("bp release inready", 32'(in_ready), 1);
    // straddling match only
    expect_frame(16'd1, 1'b0, 4'd1, 1'b0);
    send(8'b00000010, 1'b0, 3'b101);
    send(8'b10000000, 1'b1, 3'b101);
    // saturation: 3 + 5*4 = 23
    expect_frame(16'd23, 1'b0, 4'd15, 1'b1);
    for (int i = 0; i < 6; i++) send(8'b10101010, i == 5, 3'b101);
    // reset mid-frame discards everything
    send(8'b10101010, 1'b0, 3'b111);
    send(8'b11111111, 1'b0, 3'b111);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midreset outvalid", 32'(out_valid), 0);
    check("midreset inready", 32'(in_ready), 1);
    check("midreset outcount", 32'(out_count), 0);
    check("midreset outvalid4", 32'(out_valid4), 0);
    expect_frame(16'd1, 1'b0, 4'd1, 1'b0);
    send(8'b11100000, 1'b1, 3'b111);
    // pattern change after first beat ignored
    expect_frame(16'd1, 1'b0, 4'd1, 1'b0);
    send(8'b00000010, 1'b0, 3'b101);
    send(8'b10000000, 1'b1, 3'b000);
    // all-zero stream: 6 + 8 = 14, just below the 4-bit limit
    expect_frame(16'd14, 1'b0, 4'd14, 1'b0);
    send(8'b00000000, 1'b0, 3'b000);
    send(8'b00000000, 1'b1, 3'b000);
    for (int n = 0; n < 100 && (q16.size() != 0 || q4.size() != 0); n++) @(posedge clk);
    check("results drained", 32'(q16.size() + q4.size()), 0);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
